lsu_split: RTL

- Load/store sequencer directly upstream of the data memory.
- Accepts one load/store request from the core over a valid/ready handshake and drives the memory's write-enable, address, write-data and funct3 port.
- Aligned accesses pass through in a single cycle.
- Misaligned accesses are split into per-byte memory operations (sb / lbu), merged, then sign- or zero-extended.

---
 rtl/riscv_mem_pkg.sv | 33 +++
 rtl/load_extend.sv | 31 +++
 rtl/lsu_split.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: RISC-V funct3 codes, sequencer state encoding
// and the access-size / legality helpers used by the load/store sequencer.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [0:0] LSU_IDLE  = 1'b0;
    localparam logic [0:0] LSU_SPLIT = 1'b1;

    // Access size in bytes: 1/2/4/8 selected by funct3[1:0].
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    function automatic logic funct3_legal(input logic [2:0] f3, input int width);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            F3_LD, F3_LWU:                       return (width == 64);
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of merged load bytes according to the load funct3.
module load_extend
    import riscv_mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       funct3_i,
    output logic [WIDTH-1:0] data_o
);

    int                      shamt;
    logic signed [WIDTH-1:0] shifted;

    // Move the access MSB to the top, then shift back arithmetically or logically.
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   shamt = WIDTH - 8;
            2'b01:   shamt = WIDTH - 16;
            2'b10:   shamt = WIDTH - 32;
            default: shamt = 0;
        endcase
        shifted = $signed(data_i << shamt);
        if (funct3_i[2]) begin
            data_o = $unsigned(shifted) >> shamt;
        end else begin
            data_o = $unsigned(shifted >>> shamt);
        end
    end

endmodule

// File: rtl/lsu_split.sv
// Load/store sequencer in front of the data memory: aligned accesses pass
// through in one cycle, misaligned ones are split into sb/lbu byte operations.
module lsu_split
    import riscv_mem_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             resp_split,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_read_data
);

    logic [0:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             write_q, write_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] merge_q, merge_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_split_q, resp_split_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [3:0]       req_mask;
    logic             req_legal;
    logic             req_misaligned;
    logic [3:0]       split_mask;
    logic             split_last;
    logic [WIDTH-1:0] merge_cur;
    logic [WIDTH-1:0] ext_data;

    assign req_mask       = access_bytes(req_funct3) - 4'd1;
    assign req_legal      = funct3_legal(req_funct3, WIDTH);
    assign req_misaligned = (req_addr[2:0] & req_mask[2:0]) != 3'd0;
    assign split_mask     = access_bytes(funct3_q) - 4'd1;
    assign split_last     = (idx_q == split_mask[2:0]);
    assign req_ready      = (state_q == LSU_IDLE);

    // Merge view including the byte returned this cycle, so the last byte
    // can be extended without an extra cycle.
    always_comb begin
        merge_cur = merge_q;
        merge_cur[{idx_q, 3'b000} +: 8] = mem_read_data[7:0];
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .data_i   (merge_cur),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_split_d = 1'b0;
        resp_rdata_d = '0;
        mem_write    = 1'b0;
        mem_addr     = req_addr;
        mem_wr_data  = req_wdata;
        mem_funct3   = req_funct3;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (!req_legal || (req_misaligned && !ALLOW_MISALIGNED)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_misaligned) begin
                        state_d  = LSU_SPLIT;
                        idx_d    = 3'd0;
                        write_d  = req_write;
                        funct3_d = req_funct3;
                        addr_d   = req_addr;
                        wdata_d  = req_wdata;
                        merge_d  = '0;
                    end else begin
                        mem_write    = req_write;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = req_write ? '0 : mem_read_data;
                    end
                end
            end
            default: begin
                mem_addr    = addr_q + WIDTH'(idx_q);
                mem_funct3  = write_q ? F3_SB : F3_LBU;
                mem_write   = write_q;
                mem_wr_data = WIDTH'(wdata_q[{idx_q, 3'b000} +: 8]);
                merge_d     = merge_cur;
                idx_d       = idx_q + 3'd1;
                if (split_last) begin
                    state_d      = LSU_IDLE;
                    idx_d        = 3'd0;
                    resp_valid_d = 1'b1;
                    resp_split_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : ext_data;
                end
            end
        endcase

        // A reset cycle must not commit a byte of an aborted split store.
        if (reset) begin
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            idx_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_split_q <= resp_split_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q  <= write_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        merge_q  <= merge_d;
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_split = resp_split_q;
    assign resp_rdata = resp_rdata_q;

endmodule
